// File: rtl/divider_32x16_unsign_seq_if.sv
// Handshake and data bundle for the sequential unsigned divider.
//   start        : request; the divider samples it only when it is idle or done
//   dividend     : 2*width-bit unsigned dividend, captured on the accepted start edge
//   divisor      : width-bit unsigned divisor, captured on the accepted start edge
//   busy         : high while an operation is iterating
//   done         : one-cycle pulse; quotient/remainder/div_by_zero are valid
//   quotient     : 2*width-bit registered quotient
//   remainder    : width-bit registered remainder
//   div_by_zero  : registered flag; set with the results when the divisor was 0
// The master drives the request; the slave is the divider.
interface divider_32x16_unsign_seq_if #(
  parameter int width = 16
);
  logic               start;
  logic [2*width-1:0] dividend;
  logic [width-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [2*width-1:0] quotient;
  logic [width-1:0]   remainder;
  logic               div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_32x16_unsign_seq.sv
// Sequential unsigned restoring divider: a 2*width-bit dividend divided by a
// width-bit divisor, one quotient bit per clock, fixed latency of 2*width
// cycles from the accepted start edge to the done pulse.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset; aborts any operation in flight
//   bus      : slave side of divider_32x16_unsign_seq_if (start/busy/done
//              handshake, operands in, registered results out)
// A zero divisor still runs the full iteration; the results are then forced to
// quotient = all ones, remainder = low half of the dividend, div_by_zero = 1.
module divider_32x16_unsign_seq #(
  parameter int width = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  divider_32x16_unsign_seq_if.slave      bus
);

  localparam int                 DW   = 2 * width;
  localparam int                 CW   = $clog2(DW);
  localparam logic [CW-1:0]      LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [width:0]    prem_q, prem_d;     // partial remainder, width+1 bits
  logic [DW-1:0]     work_q, work_d;     // dividend bits shift out, quotient bits shift in
  logic [width-1:0]  dvs_q, dvs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     quot_q, quot_d;
  logic [width-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  // One restoring step on the current working registers.
  logic [width+1:0]  shifted;
  logic [width:0]    trial;
  logic              fits;
  logic [width:0]    step_prem;
  logic [DW-1:0]     step_work;

  always_comb begin
    shifted   = {prem_q, work_q[DW-1]};
    trial     = shifted[width:0] - {1'b0, dvs_q};
    fits      = (shifted >= {2'b00, dvs_q});
    step_prem = fits ? trial : shifted[width:0];
    step_work = {work_q[DW-2:0], fits};
  end

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          work_d  = bus.dividend;
          dvs_d   = bus.divisor;
          prem_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        prem_d = step_prem;
        work_d = step_work;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          if (dvs_q == '0) begin
            // Every trial succeeds against a zero divisor, so the partial
            // remainder has simply collected the last dividend bits.
            quot_d = '1;
            rem_d  = step_prem[width-1:0];
            dbz_d  = 1'b1;
          end else begin
            quot_d = step_work;
            rem_d  = step_prem[width-1:0];
            dbz_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears every register, datapath included, so
  // an aborted operation leaves nothing behind that a later one could observe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      work_q  <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_32x16_unsign_seq.sv
// Directed bench for divider_32x16_unsign_seq: reset values, hand-computed
// quotients/remainders, divide-by-zero, handshake corner cases, mid-operation
// reset and a back-to-back sweep over small operands.
module tb_divider_32x16_unsign_seq;

  localparam int width = 16;
  localparam int LAT   = 2 * width;

  logic clk;
  logic reset_n;

  divider_32x16_unsign_seq_if #(.width(width)) bus ();

  divider_32x16_unsign_seq #(.width(width)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Called at a negedge just after the accepting edge. Counts edges until done
  // is seen (bounded), noting whether busy stayed high and never overlapped done.
  task automatic wait_done(output int lat, output bit busy_ok, output bit overlap);
    lat     = 0;
    busy_ok = 1'b1;
    overlap = 1'b0;
    while (!bus.done && lat < LAT + 8) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy && bus.done) overlap = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] exp_q, input logic [15:0] exp_r, input logic exp_z);
    int lat;
    bit busy_ok, overlap;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, busy_ok, overlap);
    check({tag, " latency"}, lat, LAT);
    check({tag, " busy"}, busy_ok, 1'b1);
    check({tag, " overlap"}, overlap, 1'b0);
    check({tag, " quotient"}, bus.quotient, exp_q);
    check({tag, " remainder"}, bus.remainder, exp_r);
    check({tag, " dbz"}, bus.div_by_zero, exp_z);
  endtask

  initial begin
    int  lat;
    bit  busy_ok, overlap;
    int  done_seen;
    logic [31:0] cur_a;
    logic [15:0] cur_b;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst quotient", bus.quotient, 32'd0);
    check("rst remainder", bus.remainder, 16'd0);
    check("rst dbz", bus.div_by_zero, 1'b0);

    run_op("basic", 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0);
    // Results hold after the done pulse.
    repeat (3) @(negedge clk);
    check("hold done", bus.done, 1'b0);
    check("hold quotient", bus.quotient, 32'd142);
    check("hold remainder", bus.remainder, 16'd6);

    run_op("max/max", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0);
    run_op("max/1", 32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0);
    run_op("5/9", 32'd5, 16'd9, 32'd0, 16'd5, 1'b0);
    run_op("0/13", 32'd0, 16'd13, 32'd0, 16'd0, 1'b0);
    run_op("divzero", 32'h1234_5678, 16'd0, 32'hFFFF_FFFF, 16'h5678, 1'b1);

    // Start raised during RUN with other operands is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 16'd5;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < LAT + 8) begin
      @(negedge clk);
      lat++;
    end
    check("ignore latency", lat + 8, LAT);
    check("ignore quotient", bus.quotient, 32'd33);
    check("ignore remainder", bus.remainder, 16'd1);
    @(negedge clk);
    check("ignore idle after", bus.busy, 1'b0);

    // Start held through DONE launches the next operation immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd3;
    @(negedge clk);
    wait_done(lat, busy_ok, overlap);
    check("b2b first latency", lat, LAT);
    check("b2b first quotient", bus.quotient, 32'd33);
    bus.dividend = 32'd1000; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b no idle", bus.busy, 1'b1);
    wait_done(lat, busy_ok, overlap);
    check("b2b second latency", lat, LAT);
    check("b2b second busy", busy_ok, 1'b1);
    check("b2b second quotient", bus.quotient, 32'd142);
    check("b2b second remainder", bus.remainder, 16'd6);

    // Reset mid-RUN: outputs clear at once and the aborted op never reports.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst busy", bus.busy, 1'b0);
    check("midrst quotient", bus.quotient, 32'd0);
    check("midrst remainder", bus.remainder, 16'd0);
    check("midrst dbz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (LAT + 8) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("midrst no done", done_seen, 0);

    // Back-to-back sweep over all i, j in 0..31 with start held high.
    @(negedge clk);
    cur_a = 32'd0; cur_b = 16'd0;
    bus.start = 1'b1; bus.dividend = cur_a; bus.divisor = cur_b;
    @(negedge clk);
    for (int n = 0; n < 1024; n++) begin
      wait_done(lat, busy_ok, overlap);
      check("sweep latency", lat, LAT);
      if (cur_b == 16'd0) begin
        check("sweep quotient", bus.quotient, 32'hFFFF_FFFF);
        check("sweep remainder", bus.remainder, cur_a[15:0]);
        check("sweep dbz", bus.div_by_zero, 1'b1);
      end else begin
        check("sweep quotient", bus.quotient, cur_a / cur_b);
        check("sweep remainder", bus.remainder, cur_a % cur_b);
        check("sweep dbz", bus.div_by_zero, 1'b0);
      end
      if (n < 1023) begin
        cur_a = 32'((n + 1) / 32);
        cur_b = 16'((n + 1) % 32);
        bus.dividend = cur_a;
        bus.divisor  = cur_b;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (n < 1023 && !bus.busy) check("sweep no idle", bus.busy, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
